// File: rtl/prog_loader_pkg.sv
// Shared loader parameters and FSM state encoding.
// Imported by the loader and by the core that consumes its outputs.
package prog_loader_pkg;

  localparam int WORD_DEF   = 32;
  localparam int ADDR_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2,
    ST_RUN  = 2'd3
  } pl_state_e;

endpackage

// File: rtl/byte_packer.sv
// Little-endian byte-to-word assembler.
// Raises word_valid in the same cycle the last byte of a word is accepted.
module byte_packer #(
  parameter int WORD = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clr,
  input  logic            fire,
  input  logic [7:0]      data,
  output logic            word_valid,
  output logic [WORD-1:0] word
);

  localparam int NB = WORD / 8;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;

  logic [CW-1:0]   cnt;
  logic [WORD-1:0] sreg;

  // Bytes enter at the top and shift down, so byte 0 ends at [7:0].
  assign word = (WORD'(data) << (WORD - 8)) | (sreg >> 8);
  assign word_valid = fire && (cnt == CW'(NB - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      sreg <= '0;
    end else if (clr) begin
      cnt  <= '0;
      sreg <= '0;
    end else if (fire) begin
      sreg <= word;
      cnt  <= word_valid ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Streams a byte image into core memory while holding the core stalled.
// Releases the core after the last word is written.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int WORD   = WORD_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic [ADDR_W:0]   load_len,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_write,
  output logic [WORD-1:0]   mem_in,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              stall_o,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  pl_state_e         state, nstate;
  logic [ADDR_W:0]   len_q, wcnt, len_sat;
  logic [ADDR_W-1:0] addr;
  logic              fire, start, kill, wr, last;
  logic              word_valid;
  logic [WORD-1:0]   word;

  assign in_ready = (state == ST_LOAD);
  assign busy     = (state == ST_LOAD);
  assign stall_o  = (state != ST_RUN);
  assign mem_addr = addr;

  assign fire    = in_valid && in_ready;
  assign start   = load_start &&
                   ((state == ST_IDLE) || (state == ST_RUN));
  assign kill    = (state == ST_LOAD) && abort;
  assign wr      = word_valid && !abort;
  assign last    = ((wcnt + 1'b1) == len_q);
  assign len_sat = (load_len > MAX_LEN) ? MAX_LEN : load_len;

  byte_packer #(.WORD(WORD)) u_pack (
    .clk        (clk),
    .reset      (reset),
    .clr        (start || kill),
    .fire       (fire),
    .data       (in_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_comb begin
    nstate = state;
    unique case (state)
      ST_IDLE, ST_RUN: begin
        if (load_start)
          nstate = (len_sat == '0) ? ST_DONE : ST_LOAD;
      end
      ST_LOAD: begin
        if (abort)
          nstate = ST_IDLE;
        else if (word_valid && last)
          nstate = ST_DONE;
      end
      ST_DONE: nstate = ST_RUN;
      default: nstate = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      len_q     <= '0;
      wcnt      <= '0;
      addr      <= '0;
      mem_write <= 1'b0;
      mem_in    <= '0;
      done      <= 1'b0;
    end else begin
      state     <= nstate;
      mem_write <= wr;
      done      <= (state == ST_DONE);
      if (start) begin
        len_q <= len_sat;
        wcnt  <= '0;
        addr  <= '0;
      end else begin
        if (wr) begin
          mem_in <= word;
          wcnt   <= wcnt + 1'b1;
        end
        // Address advances after its write; wraps to 0 on a full bank.
        if (mem_write)
          addr <= addr + 1'b1;
      end
    end
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter WORD, default 32, meaning memory word width in bits (multiple of 8).
REQ-002 SHALL have parameter ADDR_W, default 8, meaning memory address width (256-word bank).
REQ-003 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port load_start  input  1  one-cycle request to begin loading a program image.
REQ-006 SHALL have port load_len  input  ADDR_W+1  number of words to load, sampled with load_start; legal range 0..2^ADDR_W.
REQ-007 SHALL have port abort  input  1  cancels an in-progress load.
REQ-008 SHALL have port in_valid  input  1  byte-stream valid.
REQ-009 SHALL have port in_data  input  8  byte-stream data.
REQ-010 SHALL have port in_ready  output  1  byte-stream ready; a byte transfers when in_valid and in_ready are both high on a rising edge.
REQ-011 SHALL have port mem_write  output  1  one-cycle write strobe to the core's instruction/data memory.
REQ-012 SHALL have port mem_in  output  WORD  word written when mem_write is high.
REQ-013 SHALL have port mem_addr  output  ADDR_W  word address written when mem_write is high.
REQ-014 SHALL have port stall_o  output  1  drives the core's stall_i; high holds the pipeline.
REQ-015 SHALL have port busy  output  1  high while in LOAD.
REQ-016 SHALL have port done  output  1  one-cycle pulse on successful completion.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, DONE, RUN.
REQ-018 IDLE: stall_o=1, in_ready=0; load_start -> LOAD (or -> DONE if load_len=0), latch load_len, clear address and byte counters.
REQ-019 LOAD: in_ready=1, busy=1, stall_o=1; each accepted byte is placed little-endian (first byte -> bits 7:0, byte k -> bits 8k+7:8k).
REQ-020 On acceptance of the (WORD/8)th byte of a word: mem_write=1 with mem_in = assembled word and mem_addr = current word index in the following cycle (latency 1), then address increments.
REQ-021 When the written word count equals the latched length, the FSM SHALL enter DONE in the cycle mem_write is asserted; in_ready SHALL be 0 from that cycle.
REQ-022 DONE: done=1 for exactly one cycle, stall_o=1; -> RUN unconditionally.
REQ-023 RUN: stall_o=0, in_ready=0; load_start -> LOAD (reload), stall_o rising in the same cycle as the state change.
REQ-024 abort in LOAD SHALL discard the partial word (no mem_write), -> IDLE next cycle, done not pulsed; abort in other states SHALL be ignored.
REQ-025 load_start while in LOAD or DONE SHALL be ignored.
REQ-026 load_len = 2^ADDR_W SHALL write addresses 0..2^ADDR_W-1; the address counter SHALL wrap to 0 after the last write and never issue an extra write.
REQ-027 load_len > 2^ADDR_W SHALL be saturated to 2^ADDR_W.
REQ-028 abort and final-byte acceptance in the same cycle: abort wins; no write, -> IDLE.
REQ-029 mem_write SHALL never be high for two consecutive words faster than WORD/8 accepted bytes.

Reset
REQ-030 On reset low: state=IDLE, mem_write=0, mem_in=0, mem_addr=0, in_ready=0, busy=0, done=0, stall_o=1, all counters 0; reset asserted mid-load SHALL drop the partial image without a write.

Structure
REQ-031 WORD, ADDR_W defaults and FSM state encodings SHALL live in the shared params include used by the core.
REQ-032 One sub-module, byte_packer (byte counter + little-endian shift/assembly, emitting a word-valid pulse), SHALL be used; the FSM and address counter stay in prog_loader.

Verification
REQ-033 load_len=2, bytes 13 00 00 02 / 78 56 34 12 -> mem_write at addr 0 with 02000013, addr 1 with 12345678, done one cycle later, stall_o=0 afterwards.
REQ-034 load_len=0 -> no mem_write, done pulse 2 cycles after load_start, stall_o falls next cycle.
REQ-035 in_valid toggled 1/0 every cycle with load_len=1 -> exactly one write, word correct, byte order preserved.
REQ-036 abort after 6 bytes of load_len=3 -> one write (addr 0), no second write, state IDLE, stall_o stays 1, done never pulses.
REQ-037 load_len=256 of incrementing words -> 256 writes, addr 0..255, mem_addr back at 0, no 257th write.
REQ-038 reset low mid-word then released -> all outputs at reset values, stall_o=1, a new load_start loads from addr 0 correctly.
